// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: registered 1-to-4 valid/ready demultiplexer, one-entry slot per output channel.
// Defining STREAM_DEMUX_STATS_EN adds an 8-bit delivered-beat counter per channel on out_count.
module stream_demux_1_4 #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_sel,
  input  logic [W-1:0]   in_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] out_data,
  output logic [4*8-1:0] out_count
);

  logic [3:0] slot_valid;
  logic [3:0] load;
  logic [3:0] drain;

  // Ready depends only on the selected slot, so a stalled channel never blocks beats for others.
  assign in_ready = !slot_valid[in_sel] || out_ready[in_sel];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic         valid_reg;
      logic [W-1:0] data_reg;

      assign load[gi]  = in_valid && in_ready && (in_sel == 2'(gi));
      assign drain[gi] = valid_reg && out_ready[gi];

      // A coincident load wins over the drain, so the slot stays full and sustains one beat per cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
        end else if (load[gi]) begin
          valid_reg <= 1'b1;
          data_reg  <= in_data;
        end else if (drain[gi]) begin
          valid_reg <= 1'b0;
        end
      end

      assign slot_valid[gi]      = valid_reg;
      assign out_valid[gi]       = valid_reg;
      assign out_data[gi*W +: W] = data_reg;

`ifdef STREAM_DEMUX_STATS_EN
      logic [7:0] count_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          count_reg <= 8'd0;
        end else if (drain[gi]) begin
          count_reg <= count_reg + 8'd1;
        end
      end

      assign out_count[gi*8 +: 8] = count_reg;
`else
      assign out_count[gi*8 +: 8] = 8'd0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: directed vector table, hand-written corner sequences
// and a randomised per-channel scoreboard run.
module tb_stream_demux_1_4;

`ifdef STREAM_DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [3:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [31:0] out_count;

  int tests = 0;
  int fails = 0;

  stream_demux_1_4 #(.W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [3:0]  data;
    logic [3:0]  ordy;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  logic [3:0] sbq [4][$];
  logic [3:0] prev_stall;
  logic [3:0] prev_data [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Pulse reset mid-cycle, then realign to one time unit after a rising edge.
  task automatic do_reset();
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_random();
    int accepted = 0;
    int cyc = 0;
    logic hold = 1'b0;
    logic exp_ready;
    logic [3:0] expv;
    int chk_count = 0;
    prev_stall = 4'b0000;
    while (accepted < 10000 && cyc < 60000) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 4'($urandom_range(0, 15));
      end
      out_ready = 4'($urandom_range(0, 15));
      @(negedge clk);
      exp_ready = (sbq[in_sel].size() == 0) || out_ready[in_sel];
      for (int i = 0; i < 4; i++) expv[i] = (sbq[i].size() != 0);
      // Per-cycle checks are counted but only failures are printed, to keep the log readable.
      tests += 2;
      if (in_ready !== exp_ready) begin
        fails++;
        $display("FAIL rnd_in_ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
      end
      if (out_valid !== expv) begin
        fails++;
        $display("FAIL rnd_out_valid: got %b expected %b at %0t", out_valid, expv, $time);
      end
      for (int i = 0; i < 4; i++) begin
        if (prev_stall[i]) begin
          tests++;
          if (out_valid[i] !== 1'b1 || out_data[i*4 +: 4] !== prev_data[i]) begin
            fails++;
            $display("FAIL rnd_stable ch%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid[i],
                     out_data[i*4 +: 4], prev_data[i]);
          end
        end
        if (out_valid[i] && sbq[i].size() != 0) begin
          tests++;
          if (out_data[i*4 +: 4] !== sbq[i][0]) begin
            fails++;
            $display("FAIL rnd_data ch%0d: got %h expected %h at %0t", i, out_data[i*4 +: 4],
                     sbq[i][0], $time);
          end
        end
        prev_stall[i] = out_valid[i] && !out_ready[i];
        prev_data[i]  = out_data[i*4 +: 4];
        if (out_valid[i] && out_ready[i] && sbq[i].size() != 0) void'(sbq[i].pop_front());
      end
      if (in_valid && exp_ready) begin
        sbq[in_sel].push_back(in_data);
        accepted++;
      end
      hold = in_valid && !exp_ready;
      chk_count++;
      @(posedge clk); #1;
      cyc++;
    end
    $display("rnd: %0d beats accepted in %0d cycles", accepted, cyc);
    chk("rnd_budget", 32'(accepted >= 10000), 32'd1);
    // Drain everything still held and confirm nothing was lost or duplicated.
    in_valid  = 1'b0;
    out_ready = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (out_valid[i] && sbq[i].size() != 0) begin
        chk("rnd_tail_data", 32'(out_data[i*4 +: 4]), 32'(sbq[i][0]));
        void'(sbq[i].pop_front());
      end
    end
    @(posedge clk); #1;
    chk("rnd_drained", 32'(out_valid), 32'd0);
    chk("rnd_sb_empty", 32'(sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()), 32'd0);
  endtask

  initial begin
    //           iv  sel   data  ordy     rdy   valid    data
    vecs[0] = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 16'h0000};
    vecs[1] = '{1'b1, 2'd2, 4'hA, 4'b0000, 1'b1, 4'b0100, 16'h0A00};
    vecs[2] = '{1'b1, 2'd2, 4'hB, 4'b0000, 1'b0, 4'b0100, 16'h0A00};
    vecs[3] = '{1'b1, 2'd1, 4'h5, 4'b0000, 1'b1, 4'b0110, 16'h0A50};
    vecs[4] = '{1'b0, 2'd2, 4'h0, 4'b0100, 1'b1, 4'b0010, 16'h0A50};
    vecs[5] = '{1'b1, 2'd1, 4'h7, 4'b0010, 1'b1, 4'b0010, 16'h0A70};
    vecs[6] = '{1'b1, 2'd0, 4'hC, 4'b0000, 1'b1, 4'b0011, 16'h0A7C};
    vecs[7] = '{1'b1, 2'd3, 4'hF, 4'b0000, 1'b1, 4'b1011, 16'hFA7C};
    vecs[8] = '{1'b0, 2'd3, 4'h0, 4'b0000, 1'b0, 4'b1011, 16'hFA7C};
    vecs[9] = '{1'b0, 2'd2, 4'h0, 4'b1111, 1'b1, 4'b0000, 16'hFA7C};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 4'h0;
    out_ready = 4'b1111;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_count", out_count, 32'd0);
    rst_n = 1'b1;

    // Directed vector table: in_ready checked before the edge, outputs after it.
    for (int k = 0; k < 10; k++) begin
      in_valid  = vecs[k].iv;
      in_sel    = vecs[k].sel;
      in_data   = vecs[k].data;
      out_ready = vecs[k].ordy;
      #1;
      chk($sformatf("vec%0d_in_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(vecs[k].exp_valid));
      chk($sformatf("vec%0d_out_data", k), 32'(out_data), 32'(vecs[k].exp_data));
    end
    // Drains so far: ch0 once, ch1 twice, ch2 once, ch3 once.
    chk("vec_out_count", out_count, STATS ? 32'h0101_0201 : 32'd0);

    // Full throughput into channel 3.
    do_reset();
    out_ready = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'd3;
      in_data  = 4'(k);
      #1;
      chk("thru_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      chk("thru_out_valid", 32'(out_valid), 32'b1000);
      chk("thru_data", 32'(out_data[15:12]), 32'(k));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("thru_drained", 32'(out_valid), 32'd0);
    chk("thru_count", out_count, STATS ? 32'h0800_0000 : 32'd0);

    // Mid-stream asynchronous reset with all four slots full.
    do_reset();
    out_ready = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_sel   = 2'(k);
      in_data  = 4'(8 + k);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("mid_full_valid", 32'(out_valid), 32'b1111);
    chk("mid_full_data", 32'(out_data), 32'hBA98);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 4'h3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_post_valid", 32'(out_valid), 32'b0001);
    chk("mid_post_data", 32'(out_data), 32'h0003);
    out_ready = 4'b1111;
    @(posedge clk); #1;
    chk("mid_post_drain", 32'(out_valid), 32'd0);

    // Counter wrap: 257 deliveries on channel 1.
    do_reset();
    out_ready = 4'b1111;
    in_valid  = 1'b1;
    in_sel    = 2'd1;
    for (int k = 0; k < 257; k++) begin
      in_data = 4'(k);
      @(posedge clk); #1;
      if (k == 128) chk("wrap_mid_count", out_count, STATS ? 32'h0000_8000 : 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("wrap_count", out_count, STATS ? 32'h0000_0100 : 32'd0);

    do_reset();
    run_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
